// File: rtl/mask_exp_seq_if.sv
// ---------------------------------------------------------------------------
// mask_exp_seq_if
// Groups every non-clock signal of the masked-exponent sequencer:
//   host side   : mode, start, abort, host_wr, host_sel, host_data, host_ready
//   FIFO side   : phi_wr_en, ei_wr_en, fifo_wdata, full_phi_N, full_Ei,
//                 exp_full, rd_en_expon, expon_i
//   engine side : exp_word, exp_valid, exp_ready
//   status      : busy, done, err
// Modports:
//   slave  - the sequencer itself (consumes requests, produces strobes/status)
//   master - the surrounding host / FIFO / engine environment
// ---------------------------------------------------------------------------
interface mask_exp_seq_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        mode;
    logic              start;
    logic              abort;
    logic              host_wr;
    logic              host_sel;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic              phi_wr_en;
    logic              ei_wr_en;
    logic [DATA_W-1:0] fifo_wdata;
    logic              full_phi_N;
    logic              full_Ei;
    logic              exp_full;
    logic              rd_en_expon;
    logic [DATA_W-1:0] expon_i;
    logic [DATA_W-1:0] exp_word;
    logic              exp_valid;
    logic              exp_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  mode, start, abort, host_wr, host_sel, host_data,
               exp_full, expon_i, exp_ready,
        output host_ready, phi_wr_en, ei_wr_en, fifo_wdata,
               full_phi_N, full_Ei, rd_en_expon,
               exp_word, exp_valid, busy, done, err
    );

    modport master (
        output mode, start, abort, host_wr, host_sel, host_data,
               exp_full, expon_i, exp_ready,
        input  host_ready, phi_wr_en, ei_wr_en, fifo_wdata,
               full_phi_N, full_Ei, rd_en_expon,
               exp_word, exp_valid, busy, done, err
    );
endinterface

// File: rtl/mask_exp_seq.sv
// ---------------------------------------------------------------------------
// mask_exp_seq
// Sequencer for the masked-exponent path of the RSA core. Loads Phi(N) and Ei
// words from the host into their FIFOs, enables the mask generator, waits for
// the exponent FIFO to fill, then drains masked exponent words to the modexp
// engine over a valid/ready link. Words per operand: NW = MAX_WORDS >> mode.
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset
//   bus   - mask_exp_seq_if.slave (host, FIFO, engine and status signals)
// ---------------------------------------------------------------------------
module mask_exp_seq #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 128,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 4096
) (
    input logic            clk,
    input logic            rstn,
    mask_exp_seq_if.slave  bus
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  C_ONE    = CNT_W'(1);
    localparam logic [WAIT_W-1:0] W_ONE    = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] W_TM_END = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_MASK,
        S_STREAM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_phi_cnt;
    logic [CNT_W-1:0]  r_ei_cnt;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err;
    logic              r_phi_wr_en;
    logic              r_ei_wr_en;
    logic [DATA_W-1:0] r_fifo_wdata;
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_exp_word;
    logic              r_exp_valid;

    logic [CNT_W-1:0]  w_nw;
    logic [CNT_W-1:0]  w_sel_cnt;
    logic              w_start_acc;
    logic              w_host_ready;
    logic              w_wr_acc;
    logic              w_load_done;
    logic              w_timeout;
    logic              w_xfer;
    logic              w_rd;
    logic              w_last_xfer;

    function automatic logic [CNT_W-1:0] f_nw(input logic [1:0] m);
        f_nw = CNT_W'(MAX_WORDS >> m);
    endfunction

    assign w_nw        = f_nw(r_mode);
    assign w_start_acc = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_sel_cnt   = bus.host_sel ? r_ei_cnt : r_phi_cnt;
    // abort blocks acceptance so no strobe can appear after the abort cycle
    assign w_host_ready = (r_state == S_LOAD) && !bus.abort && (w_sel_cnt < w_nw);
    assign w_wr_acc     = bus.host_wr && w_host_ready;
    // Counters are updated together with the strobe register, so once both
    // equal NW the final strobe is on the FIFO bus in this same cycle.
    assign w_load_done  = (r_phi_cnt == w_nw) && (r_ei_cnt == w_nw);
    assign w_timeout    = (r_wait_cnt == W_TM_END);
    assign w_xfer       = r_exp_valid && bus.exp_ready;
    // One read in flight at most; issue only if the output slot will be free
    // when the FIFO data arrives one cycle later.
    assign w_rd = (r_state == S_STREAM) && !bus.abort && (r_rd_cnt < w_nw) &&
                  !r_rd_pend && (!r_exp_valid || bus.exp_ready);
    assign w_last_xfer = w_xfer && ((r_tx_cnt + C_ONE) == w_nw);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start_acc) w_next = S_LOAD;
            S_LOAD:      if (w_load_done) w_next = S_WAIT_MASK;
            S_WAIT_MASK: begin
                // exp_full has priority over a coincident timeout
                if (bus.exp_full)    w_next = S_STREAM;
                else if (w_timeout)  w_next = S_IDLE;
            end
            S_STREAM:    if (w_last_xfer) w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (bus.abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode       <= 2'b00;
            r_phi_cnt    <= '0;
            r_ei_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_tx_cnt     <= '0;
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
            r_phi_wr_en  <= 1'b0;
            r_ei_wr_en   <= 1'b0;
            r_fifo_wdata <= '0;
            r_rd_pend    <= 1'b0;
            r_exp_word   <= '0;
            r_exp_valid  <= 1'b0;
        end else begin
            r_phi_wr_en <= w_wr_acc && !bus.host_sel;
            r_ei_wr_en  <= w_wr_acc && bus.host_sel;
            if (w_wr_acc) begin
                r_fifo_wdata <= bus.host_data;
                if (bus.host_sel) r_ei_cnt  <= r_ei_cnt + C_ONE;
                else              r_phi_cnt <= r_phi_cnt + C_ONE;
            end

            if (r_state == S_WAIT_MASK) begin
                r_wait_cnt <= r_wait_cnt + W_ONE;
                if (w_timeout && !bus.exp_full && !bus.abort) r_err <= 1'b1;
            end

            // Data requested last cycle is now on expon_i; the slot is free.
            if (r_rd_pend) begin
                r_exp_word  <= bus.expon_i;
                r_exp_valid <= 1'b1;
                r_rd_pend   <= 1'b0;
            end else if (w_xfer) begin
                r_exp_valid <= 1'b0;
            end
            if (w_rd) begin
                r_rd_pend <= 1'b1;
                r_rd_cnt  <= r_rd_cnt + C_ONE;
            end
            if (w_xfer) r_tx_cnt <= r_tx_cnt + C_ONE;

            if (w_start_acc) begin
                r_mode     <= bus.mode;
                r_phi_cnt  <= '0;
                r_ei_cnt   <= '0;
                r_rd_cnt   <= '0;
                r_tx_cnt   <= '0;
                r_wait_cnt <= '0;
                r_err      <= 1'b0;
            end

            if (bus.abort) begin
                r_exp_valid <= 1'b0;
                r_rd_pend   <= 1'b0;
            end
        end
    end

    assign bus.host_ready  = w_host_ready;
    assign bus.phi_wr_en   = r_phi_wr_en;
    assign bus.ei_wr_en    = r_ei_wr_en;
    assign bus.fifo_wdata  = r_fifo_wdata;
    assign bus.full_phi_N  = (r_state == S_WAIT_MASK);
    assign bus.full_Ei     = (r_state == S_WAIT_MASK);
    assign bus.rd_en_expon = w_rd;
    assign bus.exp_word    = r_exp_word;
    assign bus.exp_valid   = r_exp_valid;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.err         = r_err;

endmodule
